// File: rtl/prescaler_multi.sv
// prescaler_multi: CHANNELS independent clock dividers whose divisors can be rewritten safely while running.
// Defining PRESCALER_DUTY_EN adds a per-channel 50% duty 'phase' output.
module prescaler_multi #(
    parameter int CHANNELS  = 4,
    parameter int WIDTH     = 16,
    parameter int RESET_DIV = 25
) (
    input  logic                                            clkin,
    input  logic                                            n_rst,
    input  logic                                            en,
    input  logic                                            cfg_valid,
    output logic                                            cfg_ready,
    input  logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] cfg_ch,
    input  logic [WIDTH-1:0]                                cfg_div,
    output logic [CHANNELS-1:0]                             tick,
    output logic                                            locked
`ifdef PRESCALER_DUTY_EN
    ,
    output logic [CHANNELS-1:0]                             phase
`endif
);

    localparam logic [WIDTH-1:0] RST_DIV = WIDTH'(RESET_DIV);
    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

    logic [WIDTH-1:0]    cnt_q  [CHANNELS];
    logic [WIDTH-1:0]    cnt_d  [CHANNELS];
    logic [WIDTH-1:0]    div_q  [CHANNELS];
    logic [WIDTH-1:0]    div_d  [CHANNELS];
    logic [WIDTH-1:0]    pend_q [CHANNELS];
    logic [WIDTH-1:0]    pend_d [CHANNELS];
    logic [CHANNELS-1:0] pend_vld_q, pend_vld_d;
    logic [CHANNELS-1:0] tick_q, tick_d;
    logic [CHANNELS-1:0] seen_q, seen_d;
    logic                locked_q, locked_d;
    logic [CHANNELS-1:0] phase_q, phase_d;
    logic [CHANNELS-1:0] accept;
    logic [CHANNELS-1:0] wrap;

    // Out-of-range channel indices never match, so they read ready and are dropped.
    always_comb begin
        cfg_ready = 1'b1;
        accept    = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            if (int'(cfg_ch) == i) begin
                cfg_ready = !pend_vld_q[i];
                accept[i] = cfg_valid && !pend_vld_q[i];
            end
        end
    end

    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            wrap[i] = (cnt_q[i] == (((div_q[i] == '0) ? ONE : div_q[i]) - ONE));
        end
    end

    // A new divisor only takes effect at a wrap (or while stopped), so no period is ever cut short.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            cnt_d[i]  = cnt_q[i];
            div_d[i]  = div_q[i];
            pend_d[i] = pend_q[i];
        end
        pend_vld_d = pend_vld_q;
        tick_d     = '0;
        seen_d     = '0;
        locked_d   = 1'b0;
        phase_d    = '0;
        if (en) begin
            phase_d = phase_q;
            for (int i = 0; i < CHANNELS; i++) begin
                if (wrap[i]) begin
                    cnt_d[i]   = '0;
                    tick_d[i]  = 1'b1;
                    phase_d[i] = !phase_q[i];
                    if (accept[i]) begin
                        div_d[i] = cfg_div;
                    end else if (pend_vld_q[i]) begin
                        div_d[i]      = pend_q[i];
                        pend_vld_d[i] = 1'b0;
                    end
                end else begin
                    cnt_d[i] = cnt_q[i] + ONE;
                    if (accept[i]) begin
                        pend_d[i]     = cfg_div;
                        pend_vld_d[i] = 1'b1;
                    end
                end
            end
            seen_d   = seen_q | tick_q;
            locked_d = locked_q || (&(seen_q | tick_q));
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_d[i] = '0;
                if (pend_vld_q[i]) begin
                    div_d[i]      = pend_q[i];
                    pend_vld_d[i] = 1'b0;
                end
                if (accept[i]) begin
                    pend_d[i]     = cfg_div;
                    pend_vld_d[i] = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clkin or negedge n_rst) begin
        if (!n_rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_q[i]  <= '0;
                div_q[i]  <= RST_DIV;
                pend_q[i] <= '0;
            end
            pend_vld_q <= '0;
            tick_q     <= '0;
            seen_q     <= '0;
            locked_q   <= 1'b0;
            phase_q    <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                cnt_q[i]  <= cnt_d[i];
                div_q[i]  <= div_d[i];
                pend_q[i] <= pend_d[i];
            end
            pend_vld_q <= pend_vld_d;
            tick_q     <= tick_d;
            seen_q     <= seen_d;
            locked_q   <= locked_d;
            phase_q    <= phase_d;
        end
    end

    assign tick   = tick_q;
    assign locked = locked_q;

`ifdef PRESCALER_DUTY_EN
    assign phase = phase_q;
`else
    logic unusedPhase;
    assign unusedPhase = ^phase_q;
`endif

endmodule
